// File: rtl/exp_pkg.sv
// Shared types and constants for the experiment run controller.
// Sequencer state codes, scenario FSM state codes and default widths.
package exp_pkg;

  localparam int CNT_W         = 32;
  localparam int SHOT_W        = 16;
  localparam int RST_PULSE_LEN = 2;

  localparam logic [7:0] SCEN_IDLE     = 8'd0;
  localparam logic [7:0] SCEN_FINISHED = 8'd8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_START   = 3'd2,
    S_RELEASE = 3'd3,
    S_COOL    = 3'd4,
    S_DONE    = 3'd5,
    S_FAULT   = 3'd6,
    S_ABORT   = 3'd7
  } seq_state_t;

  function automatic logic [3:0] state_code(seq_state_t s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/experiment_sequencer_if.sv
// Host register-block bundle for the experiment sequencer.
// master: host side (commands, run config, timing); slave: sequencer (status).
interface experiment_sequencer_if #(
  parameter int CNT_W  = exp_pkg::CNT_W,
  parameter int SHOT_W = exp_pkg::SHOT_W
);

  logic              cmd_run;
  logic              cmd_abort;
  logic [SHOT_W-1:0] shot_total;
  logic [CNT_W-1:0]  cooldown_len;
  logic [CNT_W-1:0]  shot_timeout;
  logic [CNT_W-1:0]  cfg_fg_open_delay;
  logic [CNT_W-1:0]  cfg_detector_ready_timeout;
  logic [CNT_W-1:0]  cfg_detonate_len;
  logic [CNT_W-1:0]  cfg_trigger_len;
  logic              busy;
  logic              done;
  logic              error;
  logic [SHOT_W-1:0] shot_count;
  logic [3:0]        seq_state;

  modport master (
    output cmd_run, cmd_abort, shot_total,
    output cooldown_len, shot_timeout,
    output cfg_fg_open_delay, cfg_detector_ready_timeout,
    output cfg_detonate_len, cfg_trigger_len,
    input  busy, done, error, shot_count, seq_state
  );

  modport slave (
    input  cmd_run, cmd_abort, shot_total,
    input  cooldown_len, shot_timeout,
    input  cfg_fg_open_delay, cfg_detector_ready_timeout,
    input  cfg_detonate_len, cfg_trigger_len,
    output busy, done, error, shot_count, seq_state
  );

endinterface

// File: rtl/exp_pulse_gen.sv
// Fixed-length pulse generator for the scenario FSM reset line.
// Ports: clock, reset_signal, trig (1-cycle request), pulse (LEN cycles).
module exp_pulse_gen #(
  parameter int LEN = 2
) (
  input  logic clock,
  input  logic reset_signal,
  input  logic trig,
  output logic pulse
);

  localparam int W = $clog2(LEN + 1);

  logic [W-1:0] rem;

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      rem   <= '0;
      pulse <= 1'b0;
    end else if (trig) begin
      rem   <= W'(LEN - 1);
      pulse <= 1'b1;
    end else if (rem != '0) begin
      rem   <= rem - 1'b1;
      pulse <= 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/experiment_sequencer.sv
// Run controller: N back-to-back shots of the scenario FSM with cooldown,
// shadowed timing params and a per-shot watchdog.
// Ports: clock, reset_signal, host (slave bundle), scenario_state,
// exp_start/exp_reset to the FSM, par_* shadow timing values.
module experiment_sequencer #(
  parameter int CNT_W   = exp_pkg::CNT_W,
  parameter int SHOT_W  = exp_pkg::SHOT_W,
  parameter int ARM_LEN = 4
) (
  input  logic             clock,
  input  logic             reset_signal,
  experiment_sequencer_if.slave host,
  input  logic [7:0]       scenario_state,
  output logic             exp_start,
  output logic             exp_reset,
  output logic [CNT_W-1:0] par_fg_open_delay,
  output logic [CNT_W-1:0] par_detector_ready_timeout,
  output logic [CNT_W-1:0] par_detonate_len,
  output logic [CNT_W-1:0] par_trigger_len
);

  import exp_pkg::*;

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [SHOT_W-1:0] shots;
  logic              pulse_req;
  logic              watchdog;
  logic              cool_end;
  logic              abort_go;

  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
  assign watchdog = (cnt == host.shot_timeout);
  // Zero cooldown still spends one cycle in S_COOL.
  assign cool_end = (host.cooldown_len == '0) ||
                    (cnt == host.cooldown_len - 1'b1);
  assign abort_go = host.cmd_abort &&
                    (state != S_IDLE) && (state != S_ABORT);

  assign host.seq_state  = state_code(state);
  assign host.shot_count = shots;

  // pulse_req is a registered one-cycle strobe; the generator then
  // holds exp_reset for two cycles starting on the following edge.
  exp_pulse_gen #(
    .LEN (RST_PULSE_LEN)
  ) u_rst_pulse (
    .clock        (clock),
    .reset_signal (reset_signal),
    .trig         (pulse_req),
    .pulse        (exp_reset)
  );

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shots      <= '0;
      pulse_req  <= 1'b0;
      exp_start  <= 1'b0;
      host.busy  <= 1'b0;
      host.done  <= 1'b0;
      host.error <= 1'b0;
      par_fg_open_delay          <= '0;
      par_detector_ready_timeout <= '0;
      par_detonate_len           <= '0;
      par_trigger_len            <= '0;
    end else begin
      pulse_req <= 1'b0;
      if (abort_go) begin
        state     <= S_ABORT;
        exp_start <= 1'b0;
        pulse_req <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (host.cmd_run && !host.cmd_abort) begin
              par_fg_open_delay          <= host.cfg_fg_open_delay;
              par_detector_ready_timeout <= host.cfg_detector_ready_timeout;
              par_detonate_len           <= host.cfg_detonate_len;
              par_trigger_len            <= host.cfg_trigger_len;
              host.done  <= 1'b0;
              host.error <= 1'b0;
              host.busy  <= 1'b1;
              shots      <= '0;
              cnt        <= '0;
              if (host.shot_total == '0) begin
                state <= S_DONE;
              end else begin
                state     <= S_ARM;
                pulse_req <= 1'b1;
              end
            end
          end
          S_ARM: begin
            if (cnt == CNT_W'(ARM_LEN - 1)) begin
              state <= S_START;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_START: begin
            if (watchdog) begin
              state     <= S_FAULT;
              exp_start <= 1'b0;
              pulse_req <= 1'b1;
            end else if (scenario_state == SCEN_FINISHED) begin
              state     <= S_RELEASE;
              exp_start <= 1'b0;
              shots     <= shots + 1'b1;
              cnt       <= '0;
            end else begin
              exp_start <= 1'b1;
              cnt       <= cnt_inc;
            end
          end
          S_RELEASE: begin
            exp_start <= 1'b0;
            if (watchdog) begin
              state     <= S_FAULT;
              pulse_req <= 1'b1;
            end else if (scenario_state == SCEN_IDLE) begin
              state <= S_COOL;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_COOL: begin
            if (cool_end) begin
              cnt   <= '0;
              state <= (shots == host.shot_total) ? S_DONE : S_START;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_DONE: begin
            host.busy <= 1'b0;
            host.done <= 1'b1;
            state     <= S_IDLE;
          end
          S_FAULT: begin
            host.busy  <= 1'b0;
            host.error <= 1'b1;
            state      <= S_IDLE;
          end
          S_ABORT: begin
            host.busy <= 1'b0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_experiment_sequencer.sv
// Scoreboard bench for experiment_sequencer with a scenario FSM model.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_experiment_sequencer;

  logic        clock = 1'b0;
  logic        reset_signal = 1'b1;
  logic [7:0]  scenario_state = 8'd0;
  logic        exp_start;
  logic        exp_reset;
  logic [31:0] par_fg, par_drt, par_det, par_trig;

  experiment_sequencer_if host_if ();

  experiment_sequencer dut (
    .clock                      (clock),
    .reset_signal               (reset_signal),
    .host                       (host_if),
    .scenario_state             (scenario_state),
    .exp_start                  (exp_start),
    .exp_reset                  (exp_reset),
    .par_fg_open_delay          (par_fg),
    .par_detector_ready_timeout (par_drt),
    .par_detonate_len           (par_det),
    .par_trigger_len            (par_trig)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scenario FSM model: leaves IDLE on start, reports FINISHED after 50
  // start cycles, returns to IDLE once start drops; hung mode sticks in 3.
  logic hung = 1'b0;
  int   mcnt = 0;
  always @(posedge clock) begin
    if (exp_reset) begin
      scenario_state <= 8'd0;
      mcnt           <= 0;
    end else if (scenario_state == 8'd8) begin
      if (!exp_start) scenario_state <= 8'd0;
    end else if (exp_start) begin
      if (!hung && mcnt == 49) begin
        scenario_state <= 8'd8;
        mcnt           <= 0;
      end else begin
        scenario_state <= 8'd3;
        mcnt           <= mcnt + 1;
      end
    end
  end

  // Scoreboard queues per event kind.
  logic [31:0] q_rise[$];
  logic [31:0] q_fall[$];
  logic [31:0] q_rst[$];
  logic [31:0] q_end[$];

  function automatic logic [31:0] mk_rise(int sc, int g);
    return {sc[15:0], g[15:0]};
  endfunction

  function automatic logic [31:0] mk_end(int sc, bit d, bit e);
    return {sc[15:0], 14'd0, d, e};
  endfunction

  task automatic sb(input string nm, input int kind,
                    input logic [31:0] act);
    logic [31:0] exp;
    int sz;
    sz = (kind == 0) ? q_rise.size() : (kind == 1) ? q_fall.size() :
         (kind == 2) ? q_rst.size()  : q_end.size();
    if (sz == 0) begin
      n_chk++;
      $display("FAIL %s unexpected: got %0h expected none", nm, act);
      return;
    end
    case (kind)
      0: exp = q_rise.pop_front();
      1: exp = q_fall.pop_front();
      2: exp = q_rst.pop_front();
      default: exp = q_end.pop_front();
    endcase
    check(nm, {32'd0, act}, {32'd0, exp});
  endtask

  logic        p_start = 1'b0, p_rst = 1'b0, p_busy = 1'b0;
  logic [7:0]  p_scen = 8'd0;
  logic [15:0] gap = 16'hFFFF;
  int          w_start = 0, w_rst = 0;

  always @(negedge clock) begin
    if (host_if.busy && !p_busy) gap = 16'hFFFF;
    if (exp_start && !p_start)
      sb("start_rise", 0, {host_if.shot_count, gap});
    if (exp_start) w_start++;
    else if (p_start) begin
      sb("start_width", 1, w_start);
      w_start = 0;
    end
    if (exp_reset) w_rst++;
    else if (p_rst) begin
      sb("reset_width", 2, w_rst);
      w_rst = 0;
    end
    if (!host_if.busy && p_busy)
      sb("run_end", 3, {host_if.shot_count, 14'd0,
                        host_if.done, host_if.error});
    if (scenario_state == 8'd0 && p_scen != 8'd0) gap = 16'd1;
    else if (gap != 16'hFFFF) gap = gap + 16'd1;
    p_start = exp_start;
    p_rst   = exp_reset;
    p_busy  = host_if.busy;
    p_scen  = scenario_state;
  end

  task automatic start_run();
    @(posedge clock); #1 host_if.cmd_run = 1'b1;
    @(posedge clock); #1 host_if.cmd_run = 1'b0;
  endtask

  // Called right after the accepting edge N.
  task automatic check_arm(input string nm);
    @(negedge clock);
    check({nm, "_busy"}, host_if.busy, 1);
    check({nm, "_rst_n0"}, exp_reset, 0);
    @(negedge clock);
    check({nm, "_rst_n1"}, exp_reset, 1);
    repeat (3) @(negedge clock);
    check({nm, "_start_n4"}, exp_start, 0);
    @(negedge clock);
    check({nm, "_start_n5"}, exp_start, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clock);
    while ((host_if.busy || host_if.seq_state != 4'd0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({nm, "_idle_in_time"}, n < budget, 1);
    repeat (4) @(negedge clock);
  endtask

  task automatic push_shot(input int sc, input int g, input int w);
    q_rise.push_back(mk_rise(sc, g));
    q_fall.push_back(w);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    host_if.cmd_run = 1'b0;
    host_if.cmd_abort = 1'b0;
    host_if.shot_total = 16'd3;
    host_if.cooldown_len = 32'd10;
    host_if.shot_timeout = 32'd1000;
    host_if.cfg_fg_open_delay = 32'd11;
    host_if.cfg_detector_ready_timeout = 32'd22;
    host_if.cfg_detonate_len = 32'd200;
    host_if.cfg_trigger_len = 32'd33;
    repeat (3) @(posedge clock);
    #1 reset_signal = 1'b0;
    @(negedge clock);
    check("rst_busy", host_if.busy, 0);
    check("rst_done", host_if.done, 0);
    check("rst_error", host_if.error, 0);
    check("rst_shots", host_if.shot_count, 0);
    check("rst_state", host_if.seq_state, 0);
    check("rst_start", exp_start, 0);
    check("rst_exp_rst", exp_reset, 0);
    check("rst_par_det", par_det, 0);

    // Three shots, cooldown 10; cfg change and cmd_run mid-run ignored.
    q_rst.push_back(2);
    push_shot(0, 16'hFFFF, 51);
    push_shot(1, 12, 51);
    push_shot(2, 12, 51);
    q_end.push_back(mk_end(3, 1, 0));
    start_run();
    check_arm("run1");
    check("run1_par_fg", par_fg, 11);
    check("run1_par_drt", par_drt, 22);
    check("run1_par_trig", par_trig, 33);
    host_if.cfg_detonate_len = 32'd5;
    start_run();
    @(negedge clock);
    check("run1_par_det_mid", par_det, 200);
    wait_idle("run1", 2000);
    check("run1_par_det_after", par_det, 200);
    check("run1_shots", host_if.shot_count, 3);
    check("run1_done", host_if.done, 1);

    // Hung FSM: watchdog after 100 start cycles.
    hung = 1'b1;
    host_if.shot_total = 16'd1;
    host_if.shot_timeout = 32'd100;
    q_rst.push_back(2);
    push_shot(0, 16'hFFFF, 100);
    q_end.push_back(mk_end(0, 0, 1));
    q_rst.push_back(2);
    start_run();
    @(negedge clock);
    check("run2_par_det_new", par_det, 5);
    wait_idle("run2", 1000);
    check("run2_error", host_if.error, 1);
    check("run2_done", host_if.done, 0);
    hung = 1'b0;

    // Abort during shot 2 of 5.
    host_if.shot_total = 16'd5;
    host_if.shot_timeout = 32'd1000;
    q_rst.push_back(2);
    push_shot(0, 16'hFFFF, 51);
    push_shot(1, 12, 11);
    q_rst.push_back(2);
    q_end.push_back(mk_end(1, 0, 0));
    start_run();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(exp_start && host_if.shot_count == 16'd1) && n < 1000);
    check("run3_shot2_seen", n < 1000, 1);
    repeat (10) @(posedge clock);
    #1 host_if.cmd_abort = 1'b1;
    @(posedge clock);
    #1 host_if.cmd_abort = 1'b0;
    @(negedge clock);
    check("run3_start_off", exp_start, 0);
    check("run3_state_abort", host_if.seq_state, 7);
    @(negedge clock);
    check("run3_rst_on", exp_reset, 1);
    wait_idle("run3", 100);
    check("run3_error", host_if.error, 0);
    check("run3_done", host_if.done, 0);

    // run+abort together: ignored. Then shot_total=0.
    @(posedge clock);
    #1 host_if.cmd_run = 1'b1;
    host_if.cmd_abort = 1'b1;
    @(posedge clock);
    #1 host_if.cmd_run = 1'b0;
    host_if.cmd_abort = 1'b0;
    @(negedge clock);
    check("both_busy", host_if.busy, 0);
    check("both_state", host_if.seq_state, 0);
    host_if.shot_total = 16'd0;
    q_end.push_back(mk_end(0, 1, 0));
    start_run();
    @(negedge clock);
    check("zero_state_done", host_if.seq_state, 5);
    @(negedge clock);
    check("zero_done", host_if.done, 1);
    wait_idle("zero", 50);

    // Reset in S_COOL, then a normal run.
    host_if.shot_total = 16'd2;
    host_if.cooldown_len = 32'd30;
    q_rst.push_back(2);
    push_shot(0, 16'hFFFF, 51);
    q_end.push_back(mk_end(0, 0, 0));
    start_run();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (host_if.seq_state != 4'd4 && n < 1000);
    check("run4_cool_seen", n < 1000, 1);
    @(posedge clock);
    #1 reset_signal = 1'b1;
    @(posedge clock);
    #1 reset_signal = 1'b0;
    @(negedge clock);
    check("rst2_busy", host_if.busy, 0);
    check("rst2_shots", host_if.shot_count, 0);
    check("rst2_state", host_if.seq_state, 0);
    check("rst2_start", exp_start, 0);
    check("rst2_exp_rst", exp_reset, 0);
    check("rst2_par_det", par_det, 0);
    check("rst2_par_fg", par_fg, 0);
    host_if.shot_total = 16'd1;
    q_rst.push_back(2);
    push_shot(0, 16'hFFFF, 51);
    q_end.push_back(mk_end(1, 1, 0));
    start_run();
    check_arm("run5");
    wait_idle("run5", 500);
    check("run5_par_det", par_det, 5);

    repeat (5) @(negedge clock);
    check("left_rise", q_rise.size(), 0);
    check("left_fall", q_fall.size(), 0);
    check("left_rst", q_rst.size(), 0);
    check("left_end", q_end.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
